// File: rtl/mm_word_pipe.sv
// Word-serial Montgomery multiply-accumulate step: CS = (CS >> W) + A*B + D + M*U.
// Tags (valid, cp, init, last) ride a shift register alongside the arithmetic stages.
module mm_word_pipe #(
  parameter int W       = 16,
  parameter int PIPE_IN = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  input  logic           in_valid,
  input  logic           cp,
  input  logic           init,
  input  logic           last,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  input  logic [W-1:0]   M,
  input  logic [W-1:0]   M0,
  input  logic [W-1:0]   D,
  output logic           out_valid,
  output logic           out_last,
  output logic [W-1:0]   D_o,
  output logic [W+1:0]   carry_o
);

  localparam int LAT = 4 + PIPE_IN;
  localparam int PW  = 2 * W + 1;
  localparam int CW  = 2 * W + 2;

  // Tag word layout: [3] valid, [2] cp, [1] init, [0] last.
  logic [3:0]    tag_in;
  logic [3:0]    tag_q [LAT-1];
  logic [3:0]    t1;
  logic [3:0]    t2;

  logic [W-1:0]  a_i, b_i, m_i, m0_i, d_i;

  logic [PW-1:0] p0_q;
  logic [W-1:0]  a0_q, m0w_q, k0_q;
  logic [PW-1:0] p1_q;
  logic [W-1:0]  a1_q, m1_q, unew_q;
  logic [CW-1:0] p2_q;
  logic [W-1:0]  a2_q;
  logic [W-1:0]  u_q;
  logic [CW-1:0] cs_q;

  logic [W-1:0]  u_new;
  logic [W-1:0]  u_eff;
  logic [CW-1:0] p2_next;
  logic [CW-1:0] cs_next;

  // Bubbles carry no meaningful cp/init/last, so those bits are cleared on entry.
  assign tag_in = {in_valid, in_valid & cp, in_valid & init, in_valid & last};
  assign t1     = tag_q[PIPE_IN + 1];
  assign t2     = tag_q[LAT - 2];

  generate
    if (PIPE_IN != 0) begin : g_in_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          a_i  <= '0;
          b_i  <= '0;
          m_i  <= '0;
          m0_i <= '0;
          d_i  <= '0;
        end else if (ce) begin
          a_i  <= A;
          b_i  <= B;
          m_i  <= M;
          m0_i <= M0;
          d_i  <= D;
        end
      end
    end else begin : g_in_direct
      assign a_i  = A;
      assign b_i  = B;
      assign m_i  = M;
      assign m0_i = M0;
      assign d_i  = D;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT - 1; i++) tag_q[i] <= '0;
    end else if (ce) begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < LAT - 1; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign u_new   = p0_q[W-1:0] * k0_q;
  // An init word uses its own freshly computed U; later words see the held register.
  assign u_eff   = t1[1] ? unew_q : u_q;
  assign p2_next = CW'(m1_q) * CW'(u_eff) + CW'(p1_q);
  assign cs_next = (t2[1] ? '0 : (cs_q >> W)) + p2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      p0_q   <= '0;
      a0_q   <= '0;
      m0w_q  <= '0;
      k0_q   <= '0;
      p1_q   <= '0;
      a1_q   <= '0;
      m1_q   <= '0;
      unew_q <= '0;
      p2_q   <= '0;
      a2_q   <= '0;
      u_q    <= '0;
    end else if (ce) begin
      p0_q   <= PW'(a_i) * PW'(b_i) + PW'(d_i);
      a0_q   <= a_i;
      m0w_q  <= m_i;
      k0_q   <= m0_i;
      p1_q   <= p0_q;
      a1_q   <= a0_q;
      m1_q   <= m0w_q;
      unew_q <= u_new;
      p2_q   <= p2_next;
      a2_q   <= a1_q;
      if (t1[3] && !t1[2] && t1[1]) u_q <= unew_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      D_o       <= '0;
      carry_o   <= '0;
    end else if (ce) begin
      if (t2[3]) begin
        out_valid <= 1'b1;
        out_last  <= t2[0];
        if (t2[2]) begin
          D_o     <= a2_q;
          carry_o <= '0;
        end else begin
          D_o     <= cs_next[W-1:0];
          carry_o <= t2[0] ? cs_next[CW-1:W] : '0;
          cs_q    <= cs_next;
        end
      end else begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        carry_o   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mm_word_pipe.sv
// Drives a W=16/PIPE_IN=1 and a W=32/PIPE_IN=0 instance with one shared word stream
// and checks every cycle against an arithmetic Montgomery step model.
module tb_mm_word_pipe;

  typedef struct packed {
    logic        v;
    logic        lst;
    logic [31:0] d;
    logic [33:0] c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic        in_valid = 1'b0;
  logic        cp = 1'b0;
  logic        init = 1'b0;
  logic        last = 1'b0;
  logic [31:0] a = '0, b = '0, m = '0, m0 = '0, d = '0;

  logic        o16_v, o16_l;
  logic [15:0] o16_d;
  logic [17:0] o16_c;
  logic        o32_v, o32_l;
  logic [31:0] o32_d;
  logic [33:0] o32_c;

  int checks = 0;
  int failures = 0;

  exp_t exp_q16[$];
  exp_t exp_q32[$];
  exp_t last16 = '0;
  exp_t last32 = '0;

  int           wd[2] = '{16, 32};
  logic [127:0] mu[2];
  logic [127:0] mcs[2];

  always #5 clk = ~clk;

  mm_word_pipe #(.W(16), .PIPE_IN(1)) dut16 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .cp(cp), .init(init), .last(last),
    .A(a[15:0]), .B(b[15:0]), .M(m[15:0]), .M0(m0[15:0]), .D(d[15:0]),
    .out_valid(o16_v), .out_last(o16_l), .D_o(o16_d), .carry_o(o16_c)
  );

  mm_word_pipe #(.W(32), .PIPE_IN(0)) dut32 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .cp(cp), .init(init), .last(last),
    .A(a), .B(b), .M(m), .M0(m0), .D(d),
    .out_valid(o32_v), .out_last(o32_l), .D_o(o32_d), .carry_o(o32_c)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One Montgomery inner-loop step on unbounded integers, word width wd[k].
  function automatic exp_t model(input int k, input logic v_, cp_, in_, la_,
                                 input logic [31:0] a_, b_, m_, k_, d_);
    logic [127:0] mask = (128'd1 << wd[k]) - 128'd1;
    logic [127:0] aa = {96'd0, a_} & mask;
    logic [127:0] bb = {96'd0, b_} & mask;
    logic [127:0] mm = {96'd0, m_} & mask;
    logic [127:0] kk = {96'd0, k_} & mask;
    logic [127:0] dd = {96'd0, d_} & mask;
    logic [127:0] p0, p2, hi;
    exp_t e = '0;
    if (!v_) return e;
    e.v   = 1'b1;
    e.lst = la_;
    if (cp_) begin
      e.d = aa[31:0];
      return e;
    end
    p0 = aa * bb + dd;
    if (in_) mu[k] = ((p0 & mask) * kk) & mask;
    p2 = mm * mu[k] + p0;
    mcs[k] = (in_ ? 128'd0 : (mcs[k] >> wd[k])) + p2;
    hi = mcs[k] >> wd[k];
    e.d = mcs[k][31:0] & mask[31:0];
    if (la_) e.c = hi[33:0];
    return e;
  endfunction

  task automatic cmp(input string nm, input exp_t e, input logic ov, input logic ol,
                     input logic [31:0] od, input logic [33:0] oc);
    chk({nm, ".valid"}, {63'd0, ov}, {63'd0, e.v});
    chk({nm, ".last"}, {63'd0, ol}, {63'd0, e.lst});
    chk({nm, ".carry"}, {30'd0, oc}, {30'd0, e.c});
    if (e.v) chk({nm, ".d"}, {32'd0, od}, {32'd0, e.d});
  endtask

  task automatic cycle(input logic ce_, v_, cp_, in_, la_,
                       input logic [31:0] a_, b_, m_, k_, d_);
    @(negedge clk);
    ce = ce_; in_valid = v_; cp = cp_; init = in_; last = la_;
    a = a_; b = b_; m = m_; m0 = k_; d = d_;
    if (ce_) begin
      exp_q16.push_back(model(0, v_, cp_, in_, la_, a_, b_, m_, k_, d_));
      exp_q32.push_back(model(1, v_, cp_, in_, la_, a_, b_, m_, k_, d_));
    end
    @(posedge clk);
    #1;
    if (ce_) begin
      if (exp_q16.size() >= 5) last16 = exp_q16.pop_front();
      if (exp_q32.size() >= 4) last32 = exp_q32.pop_front();
    end
    cmp("w16", last16, o16_v, o16_l, {16'd0, o16_d}, {16'd0, o16_c});
    cmp("w32", last32, o32_v, o32_l, o32_d, o32_c);
  endtask

  task automatic word(input logic cp_, in_, la_, input logic [31:0] a_, b_, m_, k_, d_);
    cycle(1'b1, 1'b1, cp_, in_, la_, a_, b_, m_, k_, d_);
  endtask

  task automatic rword(input logic in_, la_);
    word(1'b0, in_, la_, $urandom, $urandom, $urandom, $urandom, $urandom);
  endtask

  // Bubbles carry random tag and data bits, which must be ignored.
  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b1, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom, $urandom, $urandom, $urandom, $urandom);
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom, $urandom, $urandom, $urandom, $urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ce = 1'($urandom);
    in_valid = 1'b1;
    init = 1'b1;
    last = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q16.delete();
    exp_q32.delete();
    mu = '{128'd0, 128'd0};
    mcs = '{128'd0, 128'd0};
    last16 = '0;
    last32 = '0;
    for (int i = 0; i < 4; i++) exp_q16.push_back('0);
    for (int i = 0; i < 3; i++) exp_q32.push_back('0);
    chk("rst16.all", {28'd0, o16_v, o16_l, o16_d, o16_c}, 64'd0);
    chk("rst32.all", {o32_v, o32_l, o32_d[29:0], 2'b00}, 64'd0);
    chk("rst32.hi", {30'd0, o32_c}, {62'd0, o32_d[31:30]});
    chk("rst32.zero", {30'd0, o32_c}, 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Single-word row from the reference example.
    word(1'b0, 1'b1, 1'b1, 32'h1, 32'h1, 32'hFFF1, 32'hEEEF, 32'h0);
    bubbles(4);
    chk("ex.flags", {62'd0, o16_v, o16_l}, 64'd3);
    chk("ex.d", {48'd0, o16_d}, 64'd0);
    chk("ex.carry", {46'd0, o16_c}, 64'h0EEE1);

    // Copy word between accumulating words leaves CS alone.
    word(1'b1, 1'b0, 1'b0, 32'h1234, $urandom, $urandom, $urandom, $urandom);
    rword(1'b0, 1'b0);
    word(1'b1, 1'b1, 1'b1, 32'hBEEF, $urandom, $urandom, $urandom, $urandom);
    rword(1'b0, 1'b1);
    bubbles(5);

    // Two-word row with a bubble between the words.
    rword(1'b1, 1'b0);
    bubbles(1);
    rword(1'b0, 1'b1);
    bubbles(5);

    // Clock-enable stall in the middle of a row.
    rword(1'b1, 1'b0);
    rword(1'b0, 1'b0);
    stall(3);
    rword(1'b0, 1'b0);
    rword(1'b0, 1'b1);
    bubbles(5);

    // Reset with words in flight, then a fresh row.
    rword(1'b1, 1'b0);
    rword(1'b0, 1'b0);
    rword(1'b0, 1'b0);
    do_reset();
    bubbles(5);
    rword(1'b1, 1'b0);
    rword(1'b0, 1'b0);
    rword(1'b0, 1'b1);
    bubbles(5);

    // Random 2048-bit rows with bubbles, stalls and occasional copy words.
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 128; j++) begin
        if ($urandom_range(0, 3) == 0) bubbles(1);
        if ($urandom_range(0, 7) == 0) stall($urandom_range(1, 3));
        if (j != 0 && j != 127 && $urandom_range(0, 31) == 0)
          word(1'b1, 1'b0, 1'b0, $urandom, $urandom, $urandom, $urandom, $urandom);
        rword(j == 0, j == 127);
      end
      if ($urandom_range(0, 1) == 0) rword(1'b1, 1'b1);
    end
    bubbles(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mm_word_pipe.md
Name: mm_word_pipe

Overview:
- Parametrised word-serial Montgomery multiply-accumulate datapath. Successor to the fixed 16-bit radix-16 pipe.
- Each valid input word computes one inner-loop step: CS = (CS >> W) + A*B + D + M*U. U = (A*B+D)[W-1:0]*M0 mod 2^W is captured on the row-start (init) word.
- Adds over the previous generation:
  - generic word width W;
  - optional input register;
  - in_valid/out_valid tagging, so bubbles are allowed;
  - explicit last-word marker that returns the top carry word, replacing the hold-and-replay trick.
- Sits under the modexp row sequencer, which supplies words and collects D_o.

Parameters:
- W, 16, word width in bits. Legal range 8..32.
- PIPE_IN, 1, 1 = register all inputs before stage 0; 0 = feed stage 0 directly.
- LAT, 4+PIPE_IN, derived (localparam). Cycles from input sample to output.

Ports:
- clk      in   1     rising-edge clock
- rst      in   1     synchronous reset, active-high
- ce       in   1     clock enable; 0 freezes the entire block
- in_valid in   1     input word valid this cycle
- cp       in   1     copy mode: pass A to D_o, no arithmetic
- init     in   1     first word of a row: compute U, clear CS
- last     in   1     last word of a row: emit carry word
- A        in   W     operand word A[i]
- B        in   W     operand word B[j]
- M        in   W     modulus word M[j]
- M0       in   W     -M^-1 mod 2^W
- D        in   W     previous-row partial result word
- out_valid out 1     D_o/carry_o valid
- out_last out  1     output word corresponds to a last-tagged input
- D_o      out  W     result word CS[W-1:0] (or A in copy mode)
- carry_o  out  W+2   CS[2W+1:W]; meaningful only when out_last=1, else 0

Behaviour:
- Reset values: all pipeline registers, valid/tag shift bits, U, CS, out_valid, out_last, D_o and carry_o are 0. Reset is synchronous, wins over ce, and may occur mid-row; in-flight words are discarded and no out_valid follows.
- ce=0: nothing updates (inputs, stages, U, CS, tags, outputs) and outputs hold. Latency counts only ce=1 cycles.
- Tags: in_valid, cp, init and last travel with their word. An in_valid=0 input is a bubble: it never changes U or CS and yields out_valid=0. The cp/init/last values on a bubble are ignored.
- Stage 0: P0 = A*B + D, 2W+1 bits.
- Stage 1:
  - init word: Unew = (P0[W-1:0]*M0) mod 2^W;
  - P1 = P0 delay.
- Stage 2:
  - P2 = M*Ueff + P1, 2W+2 bits;
  - Ueff = Unew for an init word (forwarded); otherwise the held U register;
  - the U register loads Unew on valid, non-cp init words only.
- Stage 3: on a valid, non-cp word, CSnext = (init ? 0 : CS >> W) + P2, width 2W+2, no overflow by construction.
- Output register, for a valid word:
  - copy word: D_o = A; CS unchanged; carry_o = 0;
  - normal word: D_o = CSnext[W-1:0];
  - out_last = last; carry_o = last ? CSnext[2W+1:W] : 0.
- Latency: the output appears exactly LAT ce-cycles after the input sample. Throughput is 1 word/cycle.
- init and last on the same word is legal (single-word row): U is computed, CS is cleared, and the carry is emitted together.
- A cp word with init or last set: cp dominates, and init/last are ignored for U/CS. out_last still follows last.
- Non-cp words after a last but before the next init continue to accumulate from CS >> W. The sequencer must not rely on this.
- Multipliers are inferred W x W and shall map to DSP blocks. Pipeline boundaries are as listed.

Test Plan:
- W=16, PIPE_IN=1: single word with init=last=1, A=1, B=1, D=0, M=0xFFF1, M0=0xEEEF -> after 5 cycles out_valid=1, out_last=1, D_o=0x0000, carry_o=0x0EEE1.
- cp=1, A=0x1234, followed by a normal word -> first output D_o=0x1234 with carry_o=0. The CS used by the next word is unaffected, compared against the golden model.
- Two-word row (init, then last) with a bubble inserted between the words -> one out_valid=0 cycle between the outputs. D_o and carry_o match the bit-accurate software Montgomery model.
- ce held low for 3 cycles mid-row -> outputs frozen. Results are identical to the unstalled run and delayed by 3 cycles.
- rst pulsed for 1 cycle with 3 words in flight -> next cycle all outputs are 0. No out_valid appears from the flushed words, and a fresh init row then computes correctly.
- Random 2048-bit rows (W=16, and W=32 with PIPE_IN=0, LAT=4) with random bubbles -> the word stream matches the reference model.
